// File: rtl/ldlt_fwd_solve_pkg.sv
// Shared linear-solver definitions: solver state encoding, y-store addressing,
// matrix dimension and the truncate-toward-zero bias used by fixed-point products.
package ldlt_fwd_solve_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADB  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } solve_state_t;

    // y-store address width; the store holds at most 1024 entries
    localparam int ADDR_W = 10;

    // Each node contributes six degrees of freedom
    function automatic int dim_of(input int node_num);
        return 6 * node_num;
    endfunction

    // Added to a negative product before the arithmetic right shift so the
    // shift truncates toward zero instead of toward minus infinity
    function automatic logic [63:0] trunc_bias(input int fraction);
        return (64'd1 << fraction) - 64'd1;
    endfunction

endpackage

// File: rtl/ldlt_fwd_solve_if.sv
// Stream bus of the forward solver: RHS load, LDLT factor stream in, z stream out.
interface ldlt_fwd_solve_if #(
    parameter int DATA_LEN = 32
);
    import ldlt_fwd_solve_pkg::*;

    // Valid-only handshake: a word transfers on every rising edge where its
    // valid is high and the block is in the accepting state (b words in LOADB,
    // factor words in STREAM). There is no ready; one word per cycle is taken.
    logic                i_start;
    logic                i_b_valid;
    logic [DATA_LEN-1:0] i_b_data;
    logic                i_valid;
    logic [DATA_LEN-1:0] i_data;
    logic                o_valid;
    logic [DATA_LEN-1:0] o_data;
    logic                o_done;
    logic                o_err;
    solve_state_t        dbg_state;

    modport master (
        output i_start, i_b_valid, i_b_data, i_valid, i_data,
        input  o_valid, o_data, o_done, o_err, dbg_state
    );

    modport slave (
        input  i_start, i_b_valid, i_b_data, i_valid, i_data,
        output o_valid, o_data, o_done, o_err, dbg_state
    );

endinterface

// File: rtl/fwd_solve_mac.sv
// Forward-substitution update y_out = y_in - trunc(l_ij * y_j) in fixed point,
// with the product rounded toward zero and wrapped back to the word width.
module fwd_solve_mac
    import ldlt_fwd_solve_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int FRACTION = 16
) (
    input  logic signed [DATA_LEN-1:0] y_in,
    input  logic signed [DATA_LEN-1:0] l_ij,
    input  logic signed [DATA_LEN-1:0] y_j,
    output logic signed [DATA_LEN-1:0] y_out
);

    localparam int PW = 2 * DATA_LEN;
    localparam logic signed [PW-1:0] BIAS = PW'(trunc_bias(FRACTION));

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] biased;

    always_comb begin
        prod   = PW'(l_ij) * PW'(y_j);
        biased = prod[PW-1] ? (prod + BIAS) : prod;
        y_out  = y_in - DATA_LEN'(biased >>> FRACTION);
    end

endmodule

// File: rtl/sram_dp_1024x32.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle latency
// (read-first when both ports hit the same address on the same edge).
module sram_dp_1024x32 #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic             b_re,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_re) b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/ldlt_fwd_solve.sv
// Forward solve of L*D*z = b against a streamed column-major LDLT factor:
// y starts as b, each column's off-diagonals eliminate into y, z_j = y_j / D_jj.
module ldlt_fwd_solve
    import ldlt_fwd_solve_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int NODE_NUM = 100,
    parameter int FRACTION = 16
) (
    input logic           clk,
    input logic           rst_n,
    ldlt_fwd_solve_if.slave bus
);

    localparam int DIM = dim_of(NODE_NUM);
    localparam int PW  = 2 * DATA_LEN;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DIM - 1);

    solve_state_t              state;
    logic [ADDR_W-1:0]         cnt_b, cnt_i, cnt_j;
    logic                      all_in;
    logic                      s1_valid, s1_diag, s1_last;
    logic [ADDR_W-1:0]         s1_addr;
    logic signed [DATA_LEN-1:0] s1_data;
    logic                      fwd_valid;
    logic [ADDR_W-1:0]         fwd_addr;
    logic signed [DATA_LEN-1:0] fwd_data;
    logic signed [DATA_LEN-1:0] y_j, d_jj;
    logic                      o_valid_q, o_done_q, o_err_q, done_pend;

    logic                      b_acc, e_acc, e_diag, e_last;
    logic                      a_we;
    logic [ADDR_W-1:0]         a_addr;
    logic [DATA_LEN-1:0]       a_wdata, ram_q;
    logic signed [DATA_LEN-1:0] y_cur, y_upd;
    logic signed [PW-1:0]      dividend, divisor, quotient;

    assign b_acc  = (state == ST_LOADB) && bus.i_b_valid;
    assign e_acc  = (state == ST_STREAM) && !all_in && bus.i_valid;
    assign e_diag = (cnt_i == cnt_j);
    assign e_last = e_diag && (cnt_j == LAST);

    // The most recent write always reflects current contents of its address,
    // so it safely overrides the RAM word when a read raced with that write
    assign y_cur = (fwd_valid && fwd_addr == s1_addr) ? fwd_data : ram_q;

    assign a_we    = b_acc || (s1_valid && !s1_diag);
    assign a_addr  = b_acc ? cnt_b : s1_addr;
    assign a_wdata = b_acc ? bus.i_b_data : y_upd;

    sram_dp_1024x32 #(.WIDTH(DATA_LEN), .AW(ADDR_W)) u_y_ram (
        .clk     (clk),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .b_re    (e_acc),
        .b_addr  (cnt_i),
        .b_rdata (ram_q)
    );

    fwd_solve_mac #(.DATA_LEN(DATA_LEN), .FRACTION(FRACTION)) u_mac (
        .y_in  (y_cur),
        .l_ij  (s1_data),
        .y_j   (y_j),
        .y_out (y_upd)
    );

    // Divider works from the latched (yj, Djj) pair, one stage after the diagonal
    always_comb begin
        dividend = PW'(y_j) <<< FRACTION;
        divisor  = PW'(d_jj);
        quotient = '0;
        if (d_jj != '0) quotient = dividend / divisor;
    end

    assign bus.o_valid   = o_valid_q;
    assign bus.o_data    = o_valid_q ? DATA_LEN'(quotient) : '0;
    assign bus.o_done    = o_done_q;
    assign bus.o_err     = o_err_q;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt_b     <= '0;
            cnt_i     <= '0;
            cnt_j     <= '0;
            all_in    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_diag   <= 1'b0;
            s1_last   <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            y_j       <= '0;
            d_jj      <= '0;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
            o_err_q   <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
            s1_valid  <= e_acc;
            s1_diag   <= e_diag;
            s1_last   <= e_acc && e_last;
            s1_addr   <= cnt_i;
            s1_data   <= bus.i_data;
            done_pend <= s1_valid && s1_last;

            if (a_we) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= a_addr;
                fwd_data  <= a_wdata;
            end

            if (s1_valid && s1_diag) begin
                y_j       <= y_cur;
                d_jj      <= s1_data;
                o_valid_q <= 1'b1;
                if (s1_data == '0) o_err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state   <= ST_LOADB;
                        cnt_b   <= '0;
                        cnt_i   <= '0;
                        cnt_j   <= '0;
                        all_in  <= 1'b0;
                        o_err_q <= 1'b0;
                    end
                end
                ST_LOADB: begin
                    if (b_acc) begin
                        cnt_b <= cnt_b + 1'b1;
                        if (cnt_b == LAST) state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Column j runs D_jj then L_(j+1..DIM-1),j; last column is D only
                    if (e_acc) begin
                        if (e_last) begin
                            all_in <= 1'b1;
                        end else if (cnt_i == LAST) begin
                            cnt_j <= cnt_j + 1'b1;
                            cnt_i <= cnt_j + 1'b1;
                        end else begin
                            cnt_i <= cnt_i + 1'b1;
                        end
                    end
                    if (done_pend) begin
                        state    <= ST_DONE;
                        o_done_q <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ldlt_fwd_solve.md
LDLT_FWD_SOLVE -- requirements
Module: ldlt_fwd_solve

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, word width of all data (signed two's complement, fixed point).
REQ-002 SHALL have parameter NODE_NUM, default 100; matrix dimension DIM = 6*NODE_NUM.
REQ-003 SHALL have parameter FRACTION, default 16, fractional bits of all data.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  one-cycle pulse; begins RHS load when IDLE.
REQ-007 i_b_valid  input  1  qualifies i_b_data during RHS load.
REQ-008 i_b_data  input  DATA_LEN  RHS element b_k, supplied in order k = 0..DIM-1.
REQ-009 i_valid  input  1  qualifies i_data; driven by the LDLT output o_valid.
REQ-010 i_data  input  DATA_LEN  LDLT output word, column-major lower triangle: for j = 0..DIM-1, D_jj, then L_ij for i = j+1..DIM-1.
REQ-011 o_valid  output  1  qualifies o_data.
REQ-012 o_data  output  DATA_LEN  z_j = (L^-1 b)_j / D_jj, emitted in order j = 0..DIM-1.
REQ-013 o_done  output  1  one-cycle pulse after z_(DIM-1) is emitted.
REQ-014 o_err  output  1  sticky; set when any D_jj == 0; cleared on next accepted i_start.

Function
REQ-015 SHALL implement states IDLE, LOADB, STREAM, DONE; i_start in IDLE -> LOADB; after DIM accepted b words -> STREAM; after last diagonal of column DIM-1 is processed -> DONE; DONE -> IDLE after one cycle with o_done = 1.
REQ-016 SHALL ignore i_start outside IDLE, i_b_valid outside LOADB, and i_valid outside STREAM.
REQ-017 SHALL advance the b and (i,j) counters only on qualified cycles; gaps of any length on i_b_valid/i_valid are legal; no backpressure exists, and one element per cycle SHALL be accepted sustained.
REQ-018 SHALL hold y[0..DIM-1], initialised to b during LOADB.
REQ-019 On diagonal word (i == j): SHALL latch yj = y[j] and Djj, and emit z_j = (yj << FRACTION) / Djj, signed division truncating toward zero, result truncated to DATA_LEN.
REQ-020 On off-diagonal word L_ij: SHALL update y[i] = y[i] - P, with P = (L_ij * yj) at 2*DATA_LEN, plus (2^FRACTION - 1) when negative, then arithmetically shifted right by FRACTION (truncation toward zero), wrap to DATA_LEN.
REQ-021 If Djj == 0, z_j SHALL be 0 and o_err SHALL set; processing continues.
REQ-022 o_valid SHALL assert exactly 2 cycles after the i_valid cycle carrying D_jj, for exactly one cycle; o_data SHALL be 0 when o_valid = 0.
REQ-023 Read-after-write to the same y address in consecutive elements (e.g. L_(j+1),j immediately before D_(j+1),(j+1)) SHALL use the forwarded write value, never stale SRAM data.
REQ-024 Column DIM-1 consists of its diagonal only; its processing SHALL trigger the STREAM -> DONE transition.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, all counters 0, o_valid 0, o_data 0, o_done 0, o_err 0, yj 0, Djj 0.
REQ-026 Reset mid-LOADB or mid-STREAM SHALL abandon the solve; y contents are don't-care; the next i_start begins a clean solve.

Structure
REQ-027 SHALL store y in one sram_dp_1024x32 instance (port B read, port A write, 1-cycle read latency); DIM <= 1024.
REQ-028 State encodings, DIM, and the truncate-toward-zero rounding constant SHALL live in the shared linear-solver package, reused by the LDLT block.
REQ-029 One natural sub-module: fwd_solve_mac (multiply, truncate, subtract); the divider stays inline.

Verification (NODE_NUM = 1, DIM = 6, FRACTION = 16)
REQ-030 L = I, all D = 131072 (2.0), b_k = k*65536 -> o_data = 0, 32768, 65536, 98304, 131072, 163840; o_done one cycle after the last.
REQ-031 L_10 = 32768 (0.5), other L = 0, D = 65536, b = [131072, 65536, 0, 0, 0, 0] -> z = [131072, 0, 0, 0, 0, 0]; exercises REQ-023 forwarding at columns 4/5.
REQ-032 L_10 = 0xFFFF8000 (-0.5), b0 = 1, b1 = 5, D = 65536 -> z1 = 5 (truncation toward zero, not 6).
REQ-033 D_00 = 0, remainder as REQ-030 -> z0 = 0, o_err = 1 through DONE, other z correct.
REQ-034 Run REQ-031 with a 3-cycle i_valid gap after every element -> identical z, o_valid exactly 2 cycles after each diagonal.
REQ-035 Assert rst_n low mid-STREAM, then rerun REQ-030 -> all outputs 0 during reset, correct results after.
